// File: rtl/branch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : branch_ctrl                                                   |
// | Brief    : PSR flag latch, condition evaluation, next-pc select and a    |
// |            circular return-address stack, all advanced on pulse_en.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module branch_ctrl #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       pulse_en,
    input  logic [AW-1:0]              pcPlus1,
    input  logic [2:0]                 opCode,
    input  logic [3:0]                 condType,
    input  logic [4:0]                 psrCont,
    input  logic [4:0]                 psr,
    input  logic [AW-1:0]              branchAddr,
    output logic [AW-1:0]              pcOut,
    output logic [DW-1:0]              scond,
    output logic                       taken,
    output logic [4:0]                 psrOut,
    output logic [$clog2(DEPTH):0]     rasCount,
    output logic                       rasEmpty,
    output logic                       rasFull,
    output logic                       rasOvf,
    output logic                       rasUnf
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [2:0] c_OP_NONE = 3'b000;
    localparam logic [2:0] c_OP_BJ   = 3'b001;
    localparam logic [2:0] c_OP_JAL  = 3'b010;
    localparam logic [2:0] c_OP_RET  = 3'b011;

    localparam logic [PW:0] c_DEPTH = (PW+1)'(DEPTH);

    // Flag bit positions inside psr / psrOut
    localparam int c_C = 0;
    localparam int c_L = 1;
    localparam int c_F = 2;
    localparam int c_Z = 3;
    localparam int c_N = 4;

    logic [4:0]    r_psr;
    logic [AW-1:0] r_ras [DEPTH];
    logic [PW-1:0] r_top;
    logic [PW:0]   r_count;
    logic          r_ovf;
    logic          r_unf;

    logic          w_cond_temp;
    logic          w_cond_val;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_top_inc;

    always_comb begin
        w_cond_temp = 1'b0;
        case (condType[2:0])
            3'b000:  w_cond_temp = r_psr[c_Z];
            3'b001:  w_cond_temp = r_psr[c_C];
            3'b010:  w_cond_temp = r_psr[c_L];
            3'b011:  w_cond_temp = r_psr[c_N];
            3'b100:  w_cond_temp = r_psr[c_F];
            3'b101:  w_cond_temp = r_psr[c_Z] | r_psr[c_L];
            3'b110:  w_cond_temp = r_psr[c_Z] | r_psr[c_N];
            default: w_cond_temp = 1'b1;
        endcase
    end

    assign w_cond_val = condType[3] ^ w_cond_temp;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_DEPTH);
    assign w_top_inc  = r_top + 1'b1;

    always_comb begin
        pcOut = pcPlus1;
        taken = 1'b0;
        case (opCode)
            c_OP_BJ: begin
                if (w_cond_val) begin
                    pcOut = branchAddr;
                    taken = 1'b1;
                end
            end
            c_OP_JAL: begin
                pcOut = branchAddr;
                taken = 1'b1;
            end
            c_OP_RET: begin
                if (w_cond_val) begin
                    pcOut = w_empty ? branchAddr : r_ras[r_top];
                    taken = 1'b1;
                end
            end
            default: begin
                pcOut = pcPlus1;
                taken = 1'b0;
            end
        endcase
    end

    assign w_push = pulse_en && (opCode == c_OP_JAL);
    assign w_pop  = pulse_en && (opCode == c_OP_RET) && w_cond_val;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_psr   <= '0;
            r_top   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (pulse_en) begin
            r_psr <= (psr & psrCont) | (r_psr & ~psrCont);
            if (w_push) begin
                // When full the write at top+1 lands on the oldest entry
                r_top <= w_top_inc;
                if (w_full) r_ovf   <= 1'b1;
                else        r_count <= r_count + 1'b1;
            end else if (w_pop) begin
                if (w_empty) begin
                    r_unf <= 1'b1;
                end else begin
                    r_top   <= r_top - 1'b1;
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    // Stack storage carries no reset; contents are don't-care after clr
    always_ff @(posedge clk) begin
        if (!clr && w_push) r_ras[w_top_inc] <= pcPlus1;
    end

    assign scond    = {{(DW-1){1'b0}}, w_cond_val};
    assign psrOut   = r_psr;
    assign rasCount = r_count;
    assign rasEmpty = w_empty;
    assign rasFull  = w_full;
    assign rasOvf   = r_ovf;
    assign rasUnf   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_branch_ctrl                                                |
// | Brief    : Directed self-checking bench for branch_ctrl.                 |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_branch_ctrl;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    localparam logic [2:0] c_NONE = 3'b000;
    localparam logic [2:0] c_BJ   = 3'b001;
    localparam logic [2:0] c_JAL  = 3'b010;
    localparam logic [2:0] c_RET  = 3'b011;

    logic          clk = 1'b0;
    logic          clr;
    logic          pulse_en;
    logic [AW-1:0] pcPlus1;
    logic [2:0]    opCode;
    logic [3:0]    condType;
    logic [4:0]    psrCont;
    logic [4:0]    psr;
    logic [AW-1:0] branchAddr;
    logic [AW-1:0] pcOut;
    logic [DW-1:0] scond;
    logic          taken;
    logic [4:0]    psrOut;
    logic [$clog2(DEPTH):0] rasCount;
    logic          rasEmpty;
    logic          rasFull;
    logic          rasOvf;
    logic          rasUnf;

    int n_checks = 0;
    int n_errors = 0;

    branch_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_dut (
        .clk        (clk),
        .clr        (clr),
        .pulse_en   (pulse_en),
        .pcPlus1    (pcPlus1),
        .opCode     (opCode),
        .condType   (condType),
        .psrCont    (psrCont),
        .psr        (psr),
        .branchAddr (branchAddr),
        .pcOut      (pcOut),
        .scond      (scond),
        .taken      (taken),
        .psrOut     (psrOut),
        .rasCount   (rasCount),
        .rasEmpty   (rasEmpty),
        .rasFull    (rasFull),
        .rasOvf     (rasOvf),
        .rasUnf     (rasUnf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; pulse_en = 1'b0; pcPlus1 = 32'h5; opCode = c_NONE;
        condType = 4'b0000; psrCont = 5'b0; psr = 5'b0; branchAddr = 32'h200;
        tick();
        clr = 1'b0;
        #1;
        check("rst_psr",   64'(psrOut), 64'h0);
        check("rst_count", 64'(rasCount), 64'h0);
        check("rst_empty", 64'(rasEmpty), 64'h1);
        check("rst_full",  64'(rasFull), 64'h0);
        check("rst_ovf",   64'(rasOvf), 64'h0);
        check("rst_unf",   64'(rasUnf), 64'h0);
        check("rst_pc",    64'(pcOut), 64'h5);
        check("rst_scond", 64'(scond), 64'h0);
        check("rst_taken", 64'(taken), 64'h0);

        // Latch Z only
        psr = 5'b01000; psrCont = 5'b01000; pulse_en = 1'b1;
        tick();
        pulse_en = 1'b0;
        check("latch_z", 64'(psrOut), 64'h08);

        opCode = c_BJ; condType = 4'b0000; pcPlus1 = 32'h6; #1;
        check("bj_z_pc",    64'(pcOut), 64'h200);
        check("bj_z_taken", 64'(taken), 64'h1);
        condType = 4'b1000; #1;
        check("bj_nz_pc",    64'(pcOut), 64'h6);
        check("bj_nz_scond", 64'(scond), 64'h0);
        check("bj_nz_taken", 64'(taken), 64'h0);
        condType = 4'b0001; #1;
        check("cond_c", 64'(scond), 64'h0);
        condType = 4'b0101; #1;
        check("cond_zl", 64'(scond), 64'h1);

        // Mask zero: flags hold
        opCode = c_NONE; psr = 5'b11111; psrCont = 5'b00000; pulse_en = 1'b1;
        tick();
        pulse_en = 1'b0;
        check("mask_hold", 64'(psrOut), 64'h08);
        condType = 4'b0111; #1;
        check("cond_always", 64'(scond), 64'h1);
        condType = 4'b1111; #1;
        check("cond_never", 64'(scond), 64'h0);

        // Reserved opcode behaves as NONE
        opCode = 3'b110; condType = 4'b0111; pcPlus1 = 32'h44; #1;
        check("rsvd_pc",    64'(pcOut), 64'h44);
        check("rsvd_taken", 64'(taken), 64'h0);

        // Three pushes, three pops
        opCode = c_JAL; pulse_en = 1'b1; branchAddr = 32'h999;
        for (int i = 1; i <= 3; i++) begin
            pcPlus1 = 32'(i * 16);
            #1;
            if (i == 1) check("jal_pc", 64'(pcOut), 64'h999);
            tick();
        end
        check("push3_count", 64'(rasCount), 64'h3);
        opCode = c_RET; condType = 4'b0111; pcPlus1 = 32'h77;
        for (int i = 3; i >= 1; i--) begin
            #1;
            check("pop3_pc", 64'(pcOut), 64'(i * 16));
            tick();
        end
        check("pop3_empty", 64'(rasEmpty), 64'h1);
        check("pop3_unf",   64'(rasUnf), 64'h0);

        // Overflow: nine pushes into eight entries
        opCode = c_JAL;
        for (int i = 1; i <= 9; i++) begin
            pcPlus1 = 32'(i);
            tick();
        end
        check("ovf_full",  64'(rasFull), 64'h1);
        check("ovf_flag",  64'(rasOvf), 64'h1);
        check("ovf_count", 64'(rasCount), 64'h8);
        opCode = c_RET; pcPlus1 = 32'h77;
        for (int i = 9; i >= 2; i--) begin
            #1;
            check("ovf_pop_pc", 64'(pcOut), 64'(i));
            tick();
        end
        check("ovf_drained", 64'(rasEmpty), 64'h1);
        check("ovf_sticky",  64'(rasOvf), 64'h1);

        // Underflow with fallback target
        branchAddr = 32'h100; #1;
        check("unf_pc",    64'(pcOut), 64'h100);
        check("unf_taken", 64'(taken), 64'h1);
        tick();
        check("unf_flag",  64'(rasUnf), 64'h1);
        check("unf_count", 64'(rasCount), 64'h0);
        condType = 4'b1111; pcPlus1 = 32'h78; #1;
        check("ret_nt_pc",    64'(pcOut), 64'h78);
        check("ret_nt_taken", 64'(taken), 64'h0);
        tick();
        check("unf_sticky", 64'(rasUnf), 64'h1);

        // clr overrides a simultaneous push and flag update
        opCode = c_JAL; psr = 5'b10101; psrCont = 5'b11111; clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_count", 64'(rasCount), 64'h0);
        check("clr_psr",   64'(psrOut), 64'h0);
        check("clr_ovf",   64'(rasOvf), 64'h0);
        check("clr_unf",   64'(rasUnf), 64'h0);

        // No strobe: no push, no flag load
        pulse_en = 1'b0;
        tick();
        check("nostrobe_count", 64'(rasCount), 64'h0);
        check("nostrobe_psr",   64'(psrOut), 64'h0);

        // Strobe after: push and flags land together
        pulse_en = 1'b1; pcPlus1 = 32'h55;
        tick();
        pulse_en = 1'b0;
        check("post_count", 64'(rasCount), 64'h1);
        check("post_psr",   64'(psrOut), 64'h15);
        opCode = c_RET; condType = 4'b0111; #1;
        check("post_top", 64'(pcOut), 64'h55);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/branch_ctrl.md
# branch_ctrl

Parametrised next-pc and condition unit with a hardware return-address stack. It latches selected ALU PSR flags, evaluates the instruction's condition code, and selects the next program counter. Supported ops are sequential fetch, conditional branch/jump, JAL with link push, and conditional return with link pop. It sits between the ALU/decoder and the PC register, and all state advances only on the processor's execute strobe.

## Interface
Parameters:
- AW, 32, program-counter / address width
- DW, 32, width of the scond register-file result
- DEPTH, 8, return-address-stack entries (power of 2, ≥2)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- clr  in  1  reset, synchronous, active-high; overrides pulse_en
- pulse_en  in  1  execute strobe; state updates only when high
- pcPlus1  in  AW  current pc + 1
- opCode  in  3  000 NONE, 001 BJ (Bcond/Jcond), 010 JAL, 011 RET, 1xx reserved (treated as NONE)
- condType  in  4  [2:0] condition select, [3] invert
- psrCont  in  5  per-flag latch enable mask
- psr  in  5  ALU flags {N,Z,F,L,C} (bit4..bit0)
- branchAddr  in  AW  jump/branch target; also the RET fallback target
- pcOut  out  AW  next pc (combinational)
- scond  out  DW  {zeros, condVal}
- taken  out  1  pcOut ≠ pcPlus1 path selected this cycle
- psrOut  out  5  currently latched flags
- rasCount  out  $clog2(DEPTH)+1  valid stack entries
- rasEmpty / rasFull  out  1 each  count==0 / count==DEPTH
- rasOvf / rasUnf  out  1 each  sticky overflow / underflow flags

## Operation
- Flag latch: on pulse_en, each psrOut[i] loads psr[i] if psrCont[i], else holds.
- condTemp from condType[2:0] over psrOut (latched value, before this cycle's update): 000 Z; 001 C; 010 L; 011 N; 100 F; 101 Z|L; 110 Z|N; 111 1.
- condVal = condType[3] ^ condTemp. scond = zero-extended condVal.
- Next pc:
  - NONE: pcPlus1.
  - BJ: branchAddr if condVal, else pcPlus1.
  - JAL: branchAddr unconditionally.
  - RET, condVal=1, stack non-empty: top entry.
  - RET, condVal=1, stack empty: branchAddr (fallback).
  - RET, condVal=0: pcPlus1.
- RAS: circular buffer of DEPTH×AW with top pointer and count.
  - JAL push (on pulse_en): write pcPlus1 at top+1, advance top. If count<DEPTH, count+1. If full, overwrite the oldest entry, keep count=DEPTH, set rasOvf.
  - Taken RET pop (on pulse_en): if count>0, decrement top and count. If empty, set rasUnf; pointer and count unchanged.
  - Untaken RET: no stack change.
- One op per cycle, so push and pop never coincide. The flag latch updates in the same cycle as any op.
- rasOvf and rasUnf clear only on clr.

## Timing
- pcOut, taken, scond: combinational, same cycle as inputs. Zero-cycle latency to the PC register.
- Flag, stack, count and sticky-flag updates are visible the cycle after the pulse_en edge.
- A BJ immediately after a flag-setting op sees the new flags only if that op had its own pulse_en in an earlier cycle.
- pulse_en low: outputs still computed; no state changes.
- clr (has priority over pulse_en) at the next edge sets:
  - psrOut=0, rasCount=0, top=0, rasEmpty=1, rasFull=0, rasOvf=0, rasUnf=0.
  - Stack contents don't-care.
  - A push or pop in the same cycle is discarded.
- After reset with opCode NONE: pcOut=pcPlus1, scond=0 (Z=0), taken=0.

## Test plan
- Reset, then psr=5'b01000, psrCont=5'b01000, pulse_en -> psrOut=5'b01000. Next cycle BJ with condType=4'b0000 -> pcOut=branchAddr, taken=1. With condType=4'b1000 -> pcOut=pcPlus1, scond=0.
- psrCont=0 with psr=5'b11111, pulse_en -> psrOut unchanged. condType=0111 -> scond=1; condType=1111 -> scond=0.
- JAL three times, pcPlus1=0x10/0x20/0x30 -> rasCount=3. Three taken RETs (condType=0111) -> pcOut 0x30, 0x20, 0x10. Then rasEmpty=1.
- DEPTH=8: nine JALs, pcPlus1=1..9 -> rasFull=1, rasOvf=1. Eight pops return 9 down to 2.
- RET on empty stack, branchAddr=0x100 -> pcOut=0x100, rasUnf=1, rasCount=0. Untaken RET (condType=1111) -> pcOut=pcPlus1, rasUnf unchanged.
- JAL with pulse_en and clr high together -> rasCount=0, psrOut=0 next cycle. JAL with pulse_en=0 -> no push.
